// File: rtl/led_scan_ctrl.sv
// LED scan controller: three-phase (R/G/B) multiplexed PWM drive for seven RGB LEDs.
// A shadow duty array takes host writes at any time. It is copied to the active array
// once per frame, so a frame never shows a partial update.
module led_scan_ctrl #(
  parameter int unsigned PRESCALE = 4,  // clk30 cycles per PWM tick, 1..65535
  parameter int unsigned DEADTIME = 2   // blanking ticks before each colour phase, 1..255
) (
  input  logic       clk30,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_led,
  input  logic [1:0] wr_color,
  input  logic [7:0] wr_data,
  output logic       wr_err,
  output logic       frame_start,
  output logic [6:0] led_rgb_multiplex_a,
  output logic [2:0] led_rgb_multiplex_b
);

  localparam logic [15:0] PresMax = 16'(PRESCALE - 1);
  localparam logic [7:0]  DeadMax = 8'(DEADTIME - 1);

  typedef enum logic [1:0] {StOff, StBlank, StDrive} state_e;
  typedef enum logic [1:0] {PhR = 2'd0, PhG = 2'd1, PhB = 2'd2} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  dead_q, dead_d;
  logic [7:0]  pwm_q, pwm_d;
  logic        tick;
  logic        latch;
  logic        wr_ok;
  logic        wr_bad;

  logic [7:0]  shadow_q [3][7];
  logic [7:0]  active_q [3][7];

  logic        frame_start_q;
  logic        wr_err_q;
  logic [6:0]  a_q, a_d;
  logic [2:0]  b_q, b_d;

  // The handshake is always open outside reset, so any cycle with wr_valid is a transfer.
  assign wr_ready = rst_n;
  assign wr_ok    = wr_valid && (wr_led != 3'd7) && (wr_color != 2'd3);
  assign wr_bad   = wr_valid && ((wr_led == 3'd7) || (wr_color == 2'd3));

  // Prescaler: one-cycle tick every PRESCALE cycles, held at zero while not scanning.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!enable || (state_q == StOff)) begin
      presc_d = '0;
    end else if (presc_q == PresMax) begin
      presc_d = '0;
      tick    = 1'b1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  // Scan FSM next state: blank for DEADTIME ticks, drive for 256 ticks, then next colour.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dead_d  = dead_q;
    pwm_d   = pwm_q;
    if (!enable) begin
      state_d = StOff;
      phase_d = PhR;
      dead_d  = '0;
      pwm_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StBlank;
          phase_d = PhR;
          dead_d  = '0;
          pwm_d   = '0;
        end
        StBlank: begin
          if (tick) begin
            if (dead_q == DeadMax) begin
              dead_d  = '0;
              pwm_d   = '0;
              state_d = StDrive;
            end else begin
              dead_d = dead_q + 8'd1;
            end
          end
        end
        StDrive: begin
          if (tick) begin
            pwm_d = pwm_q + 8'd1;  // wraps 255 -> 0 at the end of the phase
            if (pwm_q == 8'hff) begin
              state_d = StBlank;
              unique case (phase_q)
                PhR:     phase_d = PhG;
                PhG:     phase_d = PhB;
                default: phase_d = PhR;
              endcase
            end
          end
        end
        default: begin
          state_d = StOff;
          phase_d = PhR;
        end
      endcase
    end
  end

  // Frame latch fires on every entry to BLANK with the red phase, from OFF or from blue.
  assign latch = (state_d == StBlank) && (state_q != StBlank) && (phase_d == PhR);

  // Scan state registers.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      phase_q <= PhR;
      presc_q <= '0;
      dead_q  <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
    end
  end

  // Shadow duty array: host writes land here, invalid addresses are dropped.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int l = 0; l < 7; l++) begin
          shadow_q[c][l] <= '0;
        end
      end
    end else if (wr_ok) begin
      shadow_q[wr_color][wr_led] <= wr_data;
    end
  end

  // Active duty array: takes the pre-write shadow contents at the frame latch, so a write in
  // the latch cycle only shows up in the following frame.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int l = 0; l < 7; l++) begin
          active_q[c][l] <= '0;
        end
      end
    end else if (latch) begin
      active_q <= shadow_q;
    end
  end

  // Drive decode: colour one-hot and per-LED duty compare, only while driving.
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (enable && (state_q == StDrive)) begin
      unique case (phase_q)
        PhR:     b_d = 3'b001;
        PhG:     b_d = 3'b010;
        PhB:     b_d = 3'b100;
        default: b_d = 3'b000;
      endcase
      for (int i = 0; i < 7; i++) begin
        a_d[i] = (b_d != 3'b000) && (pwm_q < active_q[phase_q][i]);
      end
    end
  end

  // Output registers; the async reset blanks the LEDs the moment rst_n falls.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      frame_start_q <= latch;
      wr_err_q      <= wr_bad;
    end
  end

  assign led_rgb_multiplex_a = a_q;
  assign led_rgb_multiplex_b = b_q;
  assign frame_start         = frame_start_q;
  assign wr_err              = wr_err_q;

endmodule
